hdb3_stream_encoder: RTL and testbench
======================================

Name: hdb3_stream_encoder

Overview:
Full HDB3/AMI line encoder. It takes one NRZ bit per accepted input and produces the 2-bit ternary line code.
- A 4-symbol substitution window inserts B00V/000V for runs of four zeros.
- A polarity stage assigns ternary polarity to each symbol.
- Sits between the framer bit stream and the line driver.
- Adds runtime AMI/HDB3 mode, bubble-aware flush and a violation counter.

Parameters:
CNT_W, 16, width of the saturating V-insertion counter (min 2)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, synchronous, active-high
i_mode  input  1  0 = AMI (no substitution), 1 = HDB3; sampled per accepted bit
i_valid  input  1  i_bit accepted this cycle
i_bit  input  1  NRZ data bit
i_flush  input  1  shift one bubble into the window (drain)
i_clr_cnt  input  1  synchronous clear of o_v_count
o_valid  output  1  one-cycle pulse: o_hdb3_code/o_sym_type carry a symbol
o_hdb3_code  output  2  01 = +1, 10 = -1, 00 = 0 (11 never driven)
o_sym_type  output  2  00 zero, 01 mark, 10 V, 11 B
o_v_count  output  CNT_W  V symbols emitted, saturating at all-ones

Behaviour:
- Reset (i_rst=1 at an edge) clears:
  - window entries and per-stage valid bits
  - zero-run counter and mark-parity (even)
  - last-pulse polarity (set to negative, so the first pulse is +1)
  - all outputs: o_valid=0, o_hdb3_code=00, o_sym_type=00, o_v_count=0
- Reset mid-stream discards all in-flight symbols without emitting them.
- Window stages s0 (newest) to s3 (oldest), each holding a type and a valid bit.
- Advance: on i_valid, or on i_flush with i_valid=0. i_valid has priority over i_flush.
  - s3 goes to the polarity stage; s2 to s3, s1 to s2, s0 to s1.
  - s0 takes the new symbol, or a bubble (valid=0) on flush.
- No advance: window, outputs' data and state hold; o_valid=0.
- Zero-run counter:
  - increments on each accepted 0 while i_mode=1
  - clears on an accepted 1, on any flush bubble, on i_mode=0, and after a substitution
- Substitution, when the accepted 0 makes the count reach 4 (s0..s3 are then four valid zeros):
  - s0 becomes V.
  - If mark-parity is even, s3 becomes B.
  - Mark-parity counts marks and B since the last V (including this B); it clears at V.
  - After reset, parity is even, so the first run yields B00V.
- Polarity stage (registered), for each valid symbol leaving s3:
  - mark/B: polarity = opposite of the last pulse; update the last pulse.
  - V: polarity = same as the last pulse; last pulse is unchanged.
  - zero: 00.
  - Drives o_valid=1 and o_sym_type.
  - A bubble leaving s3 gives o_valid=0.
- Latency: symbol n is presented on the edge that advances the window for input n+4. Four flushes drain a full window.
- o_v_count increments on each emitted V. It holds at 2^CNT_W-1. i_clr_cnt clears it; i_clr_cnt wins over a simultaneous increment.
- Mode change applies to newly accepted bits. Symbols already in the window keep their substitution.

Decomposition:
- Package hdb3_pkg holds:
  - symbol-type localparams SYM_ZERO/SYM_MARK/SYM_V/SYM_B
  - ternary codes TERN_POS=01, TERN_NEG=10, TERN_ZERO=00
  - MODE_AMI/MODE_HDB3
- Sub-module hdb3_sym2tern holds the polarity stage: a symbol-type input with valid, the last-pulse register, and the registered outputs.
- Window, zero-run counter, parity and V counter live in the top.

Test Plan:
- HDB3 after reset, bits 1,0,0,0,0,1,0,0,0,0 then 4 flushes:
  - codes +,0,0,0,+,-,0,0,0,-
  - types M,0,0,0,V,M,0,0,0,V
  - o_v_count=2
- HDB3 after reset, eight 0s then 4 flushes:
  - codes +,0,0,+,-,0,0,-
  - types B,0,0,V,B,0,0,V
- AMI, bits 1,0,0,0,0,1 then 4 flushes: codes +,0,0,0,0,-; o_v_count stays 0.
- HDB3 with bits 0,0 then flush then 0,0, then 4 flushes: no substitution; exactly 4 o_valid pulses, all code 00.
- CNT_W=2, HDB3, 20 zeros: o_v_count reaches 3 and holds. i_clr_cnt together with a V emission gives o_v_count=0.
- Mid-stream and simultaneous controls:
  - Assert i_rst after 3 accepted bits: all outputs 0, nothing emitted.
  - i_valid and i_flush high together: the bit is accepted and no bubble is inserted.

Source files
------------

// File: rtl/hdb3_pkg.sv
// Shared symbol-type, ternary-code and mode constants for the HDB3/AMI line encoder.
package hdb3_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_MARK = 2'b01;
  localparam logic [1:0] SYM_V    = 2'b10;
  localparam logic [1:0] SYM_B    = 2'b11;

  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b10;

  localparam logic MODE_AMI  = 1'b0;
  localparam logic MODE_HDB3 = 1'b1;

  localparam int ZRUN_W = 3;

endpackage

// File: rtl/hdb3_sym2tern.sv
// Polarity stage: maps each window symbol leaving s3 to a registered ternary code,
// alternating marks/B and repeating the last polarity for V.
module hdb3_sym2tern
  import hdb3_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sym_valid,
  input  logic [1:0] i_sym_type,
  output logic       o_valid,
  output logic [1:0] o_code,
  output logic [1:0] o_sym_type
);

  logic       valid_q, valid_d;
  logic [1:0] code_q, code_d;
  logic [1:0] type_q, type_d;
  logic       last_pos_q, last_pos_d;

  // Data holds between symbols; only the valid strobe drops back to zero.
  always_comb begin
    valid_d    = 1'b0;
    code_d     = code_q;
    type_d     = type_q;
    last_pos_d = last_pos_q;
    if (i_sym_valid) begin
      valid_d = 1'b1;
      type_d  = i_sym_type;
      case (i_sym_type)
        SYM_MARK, SYM_B: begin
          code_d     = last_pos_q ? TERN_NEG : TERN_POS;
          last_pos_d = ~last_pos_q;
        end
        SYM_V:   code_d = last_pos_q ? TERN_POS : TERN_NEG;
        default: code_d = TERN_ZERO;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      code_q     <= TERN_ZERO;
      type_q     <= SYM_ZERO;
      last_pos_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      code_q     <= code_d;
      type_q     <= type_d;
      last_pos_q <= last_pos_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_code     = code_q;
  assign o_sym_type = type_q;

endmodule

// File: rtl/hdb3_stream_encoder.sv
// HDB3/AMI stream encoder: 4-symbol substitution window, zero-run/parity tracking,
// saturating V counter, feeding the registered polarity stage.
module hdb3_stream_encoder
  import hdb3_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mode,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_flush,
  input  logic             i_clr_cnt,
  output logic             o_valid,
  output logic [1:0]       o_hdb3_code,
  output logic [1:0]       o_sym_type,
  output logic [CNT_W-1:0] o_v_count
);

  logic [3:0][1:0]    win_type_q, win_type_d;
  logic [3:0]         win_vld_q, win_vld_d;
  logic [ZRUN_W-1:0]  zrun_q, zrun_d;
  logic               parity_q, parity_d;
  logic [CNT_W-1:0]   v_count_q, v_count_d;
  logic               advance;
  logic               emit_valid;
  logic [1:0]         emit_type;

  assign advance    = i_valid | i_flush;
  assign emit_valid = advance & win_vld_q[3];
  assign emit_type  = win_type_q[3];

  // Substitution rewrites the freshly shifted window: the new s0 becomes V and,
  // with even parity, the zero now in s3 becomes B. Parity is always even after a V.
  always_comb begin
    win_type_d = win_type_q;
    win_vld_d  = win_vld_q;
    zrun_d     = zrun_q;
    parity_d   = parity_q;
    if (advance) begin
      win_type_d = {win_type_q[2:0], SYM_ZERO};
      win_vld_d  = {win_vld_q[2:0], 1'b0};
      if (i_valid) begin
        win_vld_d[0] = 1'b1;
        if (i_bit) begin
          win_type_d[0] = SYM_MARK;
          zrun_d        = '0;
          parity_d      = ~parity_q;
        end else if (i_mode == MODE_HDB3) begin
          if (zrun_q == ZRUN_W'(3)) begin
            win_type_d[0] = SYM_V;
            if (!parity_q) win_type_d[3] = SYM_B;
            zrun_d   = '0;
            parity_d = 1'b0;
          end else begin
            zrun_d = zrun_q + ZRUN_W'(1);
          end
        end else begin
          zrun_d = '0;
        end
      end else begin
        zrun_d = '0;
      end
    end
  end

  always_comb begin
    v_count_d = v_count_q;
    if (i_clr_cnt) begin
      v_count_d = '0;
    end else if (emit_valid && emit_type == SYM_V && v_count_q != {CNT_W{1'b1}}) begin
      v_count_d = v_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_type_q <= '0;
      win_vld_q  <= '0;
      zrun_q     <= '0;
      parity_q   <= 1'b0;
      v_count_q  <= '0;
    end else begin
      win_type_q <= win_type_d;
      win_vld_q  <= win_vld_d;
      zrun_q     <= zrun_d;
      parity_q   <= parity_d;
      v_count_q  <= v_count_d;
    end
  end

  hdb3_sym2tern u_sym2tern (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sym_valid (emit_valid),
    .i_sym_type  (emit_type),
    .o_valid     (o_valid),
    .o_code      (o_hdb3_code),
    .o_sym_type  (o_sym_type)
  );

  assign o_v_count = v_count_q;

endmodule

// File: tb/tb_hdb3_stream_encoder.sv
// Directed bench for hdb3_stream_encoder (CNT_W=2 so saturation is reachable).
module tb_hdb3_stream_encoder;

  localparam int CNT_W = 2;
  localparam logic [1:0] P  = 2'b01;
  localparam logic [1:0] N  = 2'b10;
  localparam logic [1:0] Z  = 2'b00;
  localparam logic [1:0] TZ = 2'b00;
  localparam logic [1:0] TM = 2'b01;
  localparam logic [1:0] TV = 2'b10;
  localparam logic [1:0] TB = 2'b11;

  logic             i_clk = 1'b0;
  logic             i_rst, i_mode, i_valid, i_bit, i_flush, i_clr_cnt;
  logic             o_valid;
  logic [1:0]       o_hdb3_code, o_sym_type;
  logic [CNT_W-1:0] o_v_count;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] code_log[$];
  logic [1:0] type_log[$];
  logic [1:0] ec [10];
  logic [1:0] et [10];

  hdb3_stream_encoder #(.CNT_W(CNT_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_mode      (i_mode),
    .i_valid     (i_valid),
    .i_bit       (i_bit),
    .i_flush     (i_flush),
    .i_clr_cnt   (i_clr_cnt),
    .o_valid     (o_valid),
    .o_hdb3_code (o_hdb3_code),
    .o_sym_type  (o_sym_type),
    .o_v_count   (o_v_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock: drive, wait past the edge, log any emitted symbol.
  task automatic applyStimulus(input logic v, input logic b, input logic f, input logic c);
    i_valid = v; i_bit = b; i_flush = f; i_clr_cnt = c;
    @(posedge i_clk);
    #1;
    if (o_valid) begin
      code_log.push_back(o_hdb3_code);
      type_log.push_back(o_sym_type);
    end
    i_valid = 1'b0; i_flush = 1'b0; i_clr_cnt = 1'b0;
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    code_log.delete();
    type_log.delete();
  endtask

  task automatic sendBits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, bits[n-1-i], 1'b0, 1'b0);
  endtask

  task automatic flushN(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic checkSeq(input string tag, input int n);
    checkOutput({tag, "_count"}, code_log.size(), n);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_code%0d", tag, i),
                  (i < code_log.size()) ? int'(code_log[i]) : -1, int'(ec[i]));
      checkOutput($sformatf("%s_type%0d", tag, i),
                  (i < type_log.size()) ? int'(type_log[i]) : -1, int'(et[i]));
    end
  endtask

  initial begin
    int v_seen;
    i_rst = 1'b1; i_mode = 1'b1; i_valid = 1'b0; i_bit = 1'b0; i_flush = 1'b0; i_clr_cnt = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    doReset();
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_code", o_hdb3_code, 0);
    checkOutput("rst_type", o_sym_type, 0);
    checkOutput("rst_vcnt", o_v_count, 0);

    $display("[TB] HDB3 1,0,0,0,0,1,0,0,0,0");
    sendBits(32'b1000010000, 10);
    flushN(4);
    ec = '{P, Z, Z, Z, P, N, Z, Z, Z, N};
    et = '{TM, TZ, TZ, TZ, TV, TM, TZ, TZ, TZ, TV};
    checkSeq("hdb3_mix", 10);
    checkOutput("hdb3_mix_vcnt", o_v_count, 2);

    $display("[TB] HDB3 eight zeros");
    doReset();
    sendBits(32'b0, 8);
    flushN(4);
    ec = '{P, Z, Z, P, N, Z, Z, N, Z, Z};
    et = '{TB, TZ, TZ, TV, TB, TZ, TZ, TV, TZ, TZ};
    checkSeq("hdb3_zeros", 8);
    checkOutput("hdb3_zeros_vcnt", o_v_count, 2);

    $display("[TB] AMI 1,0,0,0,0,1");
    doReset();
    i_mode = 1'b0;
    sendBits(32'b100001, 6);
    flushN(4);
    ec = '{P, Z, Z, Z, Z, N, Z, Z, Z, Z};
    et = '{TM, TZ, TZ, TZ, TZ, TM, TZ, TZ, TZ, TZ};
    checkSeq("ami", 6);
    checkOutput("ami_vcnt", o_v_count, 0);
    i_mode = 1'b1;

    $display("[TB] zeros split by a bubble");
    doReset();
    sendBits(32'b00, 2);
    flushN(1);
    sendBits(32'b00, 2);
    flushN(4);
    ec = '{Z, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    et = '{TZ, TZ, TZ, TZ, TZ, TZ, TZ, TZ, TZ, TZ};
    checkSeq("bubble", 4);
    checkOutput("bubble_vcnt", o_v_count, 0);

    $display("[TB] V counter saturation and clear");
    doReset();
    sendBits(32'b0, 20);
    flushN(4);
    v_seen = 0;
    foreach (type_log[i]) if (type_log[i] == TV) v_seen++;
    checkOutput("sat_v_pulses", v_seen, 5);
    checkOutput("sat_vcnt", o_v_count, 3);
    sendBits(32'b0, 4);
    flushN(3);
    checkOutput("sat_hold_vcnt", o_v_count, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_v_valid", o_valid, 1);
    checkOutput("clr_v_type", o_sym_type, TV);
    checkOutput("clr_vcnt", o_v_count, 0);

    $display("[TB] reset mid-stream");
    sendBits(32'b110, 3);
    i_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    checkOutput("midrst_valid", o_valid, 0);
    checkOutput("midrst_code", o_hdb3_code, 0);
    checkOutput("midrst_type", o_sym_type, 0);
    checkOutput("midrst_vcnt", o_v_count, 0);
    code_log.delete();
    type_log.delete();
    flushN(4);
    checkOutput("midrst_drained", code_log.size(), 0);

    $display("[TB] valid and flush together");
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    sendBits(32'b000, 3);
    flushN(4);
    ec = '{P, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    et = '{TM, TZ, TZ, TZ, TZ, TZ, TZ, TZ, TZ, TZ};
    checkSeq("vld_flush", 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
